seq_mag_comp: RTL and testbench
===============================

Name: seq_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. It produces the a>b, a<b and a==b flags.
- Operands are latched on a start handshake and scanned MSB-first, DIGIT bits per clock.
- The scan terminates early at the first differing digit.
- Supports unsigned and two's-complement signed compare, selected per operation.
- Used where wide compares must not sit on a single-cycle critical path.

Parameters:
- WIDTH, 16: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits compared per clock. WIDTH % DIGIT must be 0; elaboration fails otherwise.
- NDIG (localparam), WIDTH/DIGIT: number of digits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; result is valid from this cycle.
- agb  output  1  a > b.
- alb  output  1  a < b.
- aeb  output  1  a == b.

Behaviour:
- Reset: state IDLE, busy=0, done=0, agb=0, alb=0, aeb=0, index cleared. Reset has priority over everything, including mid-operation. No done pulse is produced for an aborted operation.
- States: IDLE and RUN.
- IDLE, start=1 at edge t:
  - Latch a, b and signed_mode into internal registers.
  - If signed_mode=1, invert bit WIDTH-1 of both latched operands. A signed compare then equals an unsigned compare of the modified values.
  - Set idx=0 (MSB digit) and go to RUN. busy=1 from edge t.
- RUN, each edge: compare digit idx of latched A vs latched B (bits WIDTH-1-idx*DIGIT down to WIDTH-DIGIT-idx*DIGIT), unsigned.
  - Digits differ: register agb/alb from that digit, aeb=0, done=1, busy=0, go to IDLE.
  - Digits equal and idx==NDIG-1: register aeb=1, agb=0, alb=0, done=1, busy=0, go to IDLE.
  - Digits equal otherwise: idx++ and stay in RUN.
- Latency: done is high in the cycle after edge t+j+1.
  - j = index of the first differing digit, or NDIG-1 if the operands are equal.
  - Range: 1 to NDIG compare cycles.
- done is high for exactly one cycle. agb/alb/aeb are one-hot after the first done.
- Result flags hold until the next done; they are not cleared by a new start.
- start while busy=1 is ignored. The operation in flight is unaffected.
- start is accepted in the cycle where done=1, since the state is already IDLE. Back-to-back operations therefore lose no cycles. Old flags stay visible until the new done.
- a, b and signed_mode may change freely after start is accepted; only latched copies are used.
- Exactly one flag is set per result. An all-flags-zero state exists only after reset before the first done.

Test Plan (WIDTH=8, DIGIT=2, NDIG=4):
1. Unsigned, a=0x80, b=0x7F, start at edge t -> MSB digit differs; done at t+1 with agb=1, alb=0, aeb=0; busy low after t+1.
2. Unsigned, a=0x5A, b=0x5A -> done at t+4 with aeb=1, agb=0, alb=0; busy high for 4 cycles.
3. Unsigned, a=0x5B, b=0x5A -> LSB digit decides; done at t+4 with agb=1. Then a=0x5A, b=0x5B -> done with alb=1.
4. signed_mode=1, a=0x80 (-128), b=0x7F (+127) -> done at t+1 with alb=1. With signed_mode=0 and the same operands -> agb=1.
5. Start a=0x01, b=0x02 (4-cycle op). Pulse start with a=0xFF, b=0x00 at t+2 -> ignored; single done at t+4 with alb=1. Assert new start in the done cycle -> accepted; next done follows correctly.
6. Start a=0x5A, b=0x5A, then assert rst at t+2 -> done never pulses, busy=0, all flags 0. start after reset releases -> normal operation resumes.

Source files
------------

// File: rtl/seq_mag_comp.sv
// seq_mag_comp: multi-cycle magnitude comparator.
// Operands are latched on start and scanned MSB-first, DIGIT bits per clock,
// stopping at the first differing digit. Signed compares are reduced to
// unsigned ones by flipping the sign bit of both latched operands.
module seq_mag_comp #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             alb,
  output logic             aeb
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned SHW  = $clog2(WIDTH) + 1;

  // Reject illegal parameter combinations at elaboration
  if (WIDTH < 2) begin : g_bad_width
    $error("seq_mag_comp: WIDTH must be at least 2");
  end
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_mag_comp: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_agb;
  logic             r_alb;
  logic             r_aeb;

  logic [WIDTH-1:0] w_flip;
  logic [SHW-1:0]   w_shamt;
  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic             w_last;

  // Sign-bit mask applied at latch time for two's-complement compares
  assign w_flip  = {signed_mode, {(WIDTH-1){1'b0}}};

  // Select the current digit (idx 0 is the most significant one)
  assign w_shamt = SHW'(WIDTH - DIGIT) - SHW'(SHW'(r_idx) * SHW'(DIGIT));
  assign w_dig_a = DIGIT'(r_a >> w_shamt);
  assign w_dig_b = DIGIT'(r_b >> w_shamt);
  assign w_last  = (r_idx == IDXW'(NDIG - 1));

  // Control FSM, operand latches and registered result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_agb   <= 1'b0;
      r_alb   <= 1'b0;
      r_aeb   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a ^ w_flip;
            r_b     <= b ^ w_flip;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_dig_a != w_dig_b) begin
            r_agb   <= (w_dig_a > w_dig_b);
            r_alb   <= (w_dig_a < w_dig_b);
            r_aeb   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_agb   <= 1'b0;
            r_alb   <= 1'b0;
            r_aeb   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + IDXW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign agb  = r_agb;
  assign alb  = r_alb;
  assign aeb  = r_aeb;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp with WIDTH=8, DIGIT=2: directed cases plus random
// operations checked against an arithmetic reference model.
module tb_seq_mag_comp;

  localparam int unsigned W  = 8;
  localparam int unsigned DG = 2;
  localparam int unsigned ND = W / DG;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_mode;
  logic         busy;
  logic         done;
  logic         agb;
  logic         alb;
  logic         aeb;

  int       n_checks = 0;
  int       n_fail   = 0;
  logic [2:0] prev_fl = 3'b000;
  logic [2:0] exp_fl;
  int         exp_lat;

  always #5 clk = ~clk;

  seq_mag_comp #(.WIDTH(W), .DIGIT(DG)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .agb         (agb),
    .alb         (alb),
    .aeb         (aeb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: flags from integer compare, latency from the highest differing bit
  task automatic ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                         output logic [2:0] fl, output int lat);
    logic gt, lt;
    logic [W-1:0] d;
    int p;
    if (sm) begin
      gt = ($signed(x) > $signed(y));
      lt = ($signed(x) < $signed(y));
    end else begin
      gt = (x > y);
      lt = (x < y);
    end
    fl = {gt, lt, (x == y)};
    d = x ^ y;
    p = -1;
    for (int i = 0; i < int'(W); i++) if (d[i]) p = i;
    lat = (p < 0) ? int'(ND) : ((int'(W) - 1 - p) / int'(DG)) + 1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an operation at the current negedge and let one edge accept it
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    start = 1'b1;
    a = x;
    b = y;
    signed_mode = sm;
    ref_cmp(x, y, sm, exp_fl, exp_lat);
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    signed_mode = 1'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait (bounded) for done, then check latency and flags
  task automatic finish_op(input string tag, input int already);
    int cyc;
    cyc = already;
    while (done !== 1'b1 && cyc < int'(ND) + 2) begin
      step();
      cyc++;
      if (done !== 1'b1) begin
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        chk({tag, "_flags_hold"}, 32'({agb, alb, aeb}), 32'(prev_fl));
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_flags"}, 32'({agb, alb, aeb}), 32'(exp_fl));
    prev_fl = exp_fl;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sm);
    launch(x, y, sm);
    finish_op(tag, 0);
  endtask

  task automatic idle_check(input string tag);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_flags_idle"}, 32'({agb, alb, aeb}), 32'(prev_fl));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_flags", 32'({agb, alb, aeb}), 32'd0);
    rst = 1'b0;
    idle_check("post_reset");

    // MSB digit decides immediately
    do_op("t1_msb", 8'h80, 8'h7F, 1'b0);
    idle_check("t1");

    // Equal operands scan all digits
    do_op("t2_eq", 8'h5A, 8'h5A, 1'b0);
    idle_check("t2");

    // LSB digit decides, back-to-back
    do_op("t3_gt", 8'h5B, 8'h5A, 1'b0);
    do_op("t3_lt", 8'h5A, 8'h5B, 1'b0);
    idle_check("t3");

    // Signed versus unsigned on the same operands
    do_op("t4_signed", 8'h80, 8'h7F, 1'b1);
    do_op("t4_unsigned", 8'h80, 8'h7F, 1'b0);
    idle_check("t4");

    // start while busy is ignored; start in the done cycle is accepted
    launch(8'h01, 8'h02, 1'b0);
    step();
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    signed_mode = 1'b0;
    step();
    start = 1'b0;
    finish_op("t5_ignored", 2);
    launch(8'hC3, 8'hC1, 1'b1);
    finish_op("t5_b2b", 0);
    idle_check("t5");

    // Reset aborts an operation without a done pulse
    launch(8'h5A, 8'h5A, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_flags", 32'({agb, alb, aeb}), 32'd0);
    prev_fl = 3'b000;
    repeat (4) begin
      step();
      chk("t6_no_done", 32'(done), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);
    end
    do_op("t6_resume", 8'h12, 8'h34, 1'b0);
    idle_check("t6");

    // Random operations, some with single-bit differences
    for (int n = 0; n < 80; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? (ra ^ W'(1 << $urandom_range(0, W - 1))) :
           ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
      do_op("rand", ra, rb, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
